// File: rtl/mem_fifo.sv
// mem_fifo: single-clock FIFO over a DATA_W x DEPTH register array, with a
// registered read port, occupancy-derived status and sticky error flags.
module mem_fifo #(
   parameter int DATA_W   = 4,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              wr_acc, rd_acc;

   // Status is decoded only from registered count, so no enable reaches it combinationally.
   assign full        = (count_q == CW'(DEPTH));
   assign empty       = (count_q == '0);
   assign almost_full = (count_q >= CW'(AF_LEVEL));
   assign count       = count_q;
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;

   always_comb begin
      wr_acc     = wr_en & ~full;
      rd_acc     = rd_en & ~empty;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_acc;
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) begin
         rd_ptr_d  = rd_ptr_q + AW'(1);
         rd_data_d = mem_q[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // A new error event in the same cycle as clr_err keeps the flag set.
      ovf_d = (wr_en & full)  | (ovf_q & ~clr_err);
      unf_d = (rd_en & empty) | (unf_q & ~clr_err);
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

endmodule
